// File: rtl/count_dir_pkg.sv
// Shared types and constants for the 2-bit count direction decoder.
// The state enum and delta codes are used by the top-level decoder.
package count_dir_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [1:0] D_HOLD = 2'd0;
    localparam logic [1:0] D_UP   = 2'd1;
    localparam logic [1:0] D_ILL  = 2'd2;
    localparam logic [1:0] D_DN   = 2'd3;

    // Step size between two observed count values on the 4-position ring.
    function automatic logic [1:0] ring_delta(input logic [1:0] cur, input logic [1:0] last);
        return cur - last;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a bus whose bits change one value at a time.
// Both stages clear to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // NOTE: non-blocking assignments so q takes the previous value of s1, forming two stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/count_dir_decoder.sv
// Recovers direction and signed position from a free-running 2-bit count stream,
// flagging double jumps as sticky errors.
module count_dir_decoder
    import count_dir_pkg::*;
#(
    parameter int POS_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              q_in,
    input  logic                    clr,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    logic [1:0] s2;
    logic [1:0] prev;
    logic [1:0] delta;
    state_t     state;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (s2)
    );

    always_comb begin
        delta = ring_delta(s2, prev);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
            prev  <= 2'd0;
            pos   <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clr) begin
                // Any step decoded this cycle is dropped; dir keeps its last value.
                state <= ST_INIT;
                pos   <= '0;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        prev  <= s2;
                        state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        case (delta)
                            D_UP: begin
                                pos  <= pos + POS_ONE;
                                dir  <= 1'b1;
                                step <= 1'b1;
                                prev <= s2;
                            end
                            D_DN: begin
                                pos  <= pos - POS_ONE;
                                dir  <= 1'b0;
                                step <= 1'b1;
                                prev <= s2;
                            end
                            D_ILL: begin
                                // Resynchronise on the new value so one glitch costs one error.
                                err  <= 1'b1;
                                prev <= s2;
                            end
                            default: begin
                            end
                        endcase
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

endmodule
